bpsk_bit_sync: RTL and testbench

BPSK symbol timing recovery and bit slicer. It sits directly downstream of the Costas carrier-recovery loop and consumes the low-pass-filtered I-arm baseband (the 32-bit demod output). It integrates each symbol, slices its sign into a hard bit, and trims the symbol boundary ±1 sample per symbol from observed zero crossings. An optional lock detector reports stable demodulation.

---
 rtl/bpsk_bit_sync_if.sv | 30 +++
 rtl/bpsk_bit_sync.sv | 163 ++++++++++++++++
 tb/tb_bpsk_bit_sync.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bpsk_bit_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_bit_sync_if
// Purpose  : Sample-in / hard-bit-out bundle for the BPSK bit synchroniser.
// Revision : 1.0
// ============================================================================
interface bpsk_bit_sync_if #(
  parameter int DW = 32
);
  localparam int AW = DW + 7;

  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 bit_out;
  logic                 bit_valid;
  logic signed [AW-1:0] sym_acc;
  logic [1:0]           timing_adj;
  logic                 lock;

  modport master (
    output din, din_valid,
    input  bit_out, bit_valid, sym_acc, timing_adj, lock
  );

  modport slave (
    input  din, din_valid,
    output bit_out, bit_valid, sym_acc, timing_adj, lock
  );
endinterface
`default_nettype wire

// File: rtl/bpsk_bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_bit_sync
// Purpose  : Integrate-and-dump BPSK slicer with +/-1 sample boundary trim.
//            Optional lock detector enabled by defining LOCK_DET_EN.
// Revision : 1.0
// ============================================================================
module bpsk_bit_sync #(
  parameter int            DW      = 32,
  parameter int            SPS     = 50,
  parameter logic [DW+6:0] LOCK_TH = (DW+7)'(20000)
) (
  input  wire logic      sys_clk,
  input  wire logic      sys_rst,
  bpsk_bit_sync_if.slave bus
);
  localparam int         AW        = DW + 7;
  localparam logic [6:0] c_end_nom = 7'(SPS - 1);
  localparam logic [6:0] c_end_ext = 7'(SPS);
  localparam logic [6:0] c_end_shr = 7'(SPS - 2);
  localparam logic [6:0] c_half    = 7'(SPS / 2);

  logic [6:0]           cnt_q, cnt_d;
  logic [6:0]           end_q, end_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 sgn_q, sgn_d;
  logic                 xflag_q, xflag_d;
  logic [6:0]           xpos_q, xpos_d;
  logic                 bit_q, bit_d;
  logic                 bv_q, bv_d;
  logic signed [AW-1:0] sym_q, sym_d;
  logic [1:0]           adj_q, adj_d;

  logic signed [AW-1:0] w_din_ext;
  logic signed [AW-1:0] w_final;
  logic                 w_sgn;
  logic                 w_cross;
  logic                 w_dump;
  logic                 w_xflag;
  logic [6:0]           w_xpos;

  always_comb begin
    w_din_ext = {{(AW-DW){bus.din[DW-1]}}, bus.din};
    w_final   = acc_q + w_din_ext;
    w_sgn     = bus.din[DW-1];
    w_cross   = w_sgn ^ sgn_q;
    w_dump    = bus.din_valid && (cnt_q == end_q);
    // A crossing on the dump sample still counts toward this symbol's decision.
    w_xflag   = xflag_q | w_cross;
    w_xpos    = xflag_q ? xpos_q : cnt_q;

    cnt_d   = cnt_q;
    end_d   = end_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    xflag_d = xflag_q;
    xpos_d  = xpos_q;
    bit_d   = bit_q;
    sym_d   = sym_q;
    bv_d    = 1'b0;
    adj_d   = 2'b00;

    if (bus.din_valid) begin
      sgn_d = w_sgn;
      if (w_dump) begin
        cnt_d   = '0;
        acc_d   = '0;
        xflag_d = 1'b0;
        xpos_d  = '0;
        sym_d   = w_final;
        bit_d   = ~w_final[AW-1];
        bv_d    = 1'b1;
        if (!w_xflag || (w_xpos == 7'd0)) begin
          end_d = c_end_nom;
        end else if (w_xpos < c_half) begin
          end_d = c_end_ext;
          adj_d = 2'b01;
        end else begin
          end_d = c_end_shr;
          adj_d = 2'b10;
        end
      end else begin
        cnt_d = cnt_q + 7'd1;
        acc_d = w_final;
        if (w_cross && !xflag_q) begin
          xflag_d = 1'b1;
          xpos_d  = cnt_q;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q   <= '0;
      end_q   <= c_end_nom;
      acc_q   <= '0;
      sgn_q   <= 1'b0;
      xflag_q <= 1'b0;
      xpos_q  <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
      sym_q   <= '0;
      adj_q   <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      acc_q   <= acc_d;
      sgn_q   <= sgn_d;
      xflag_q <= xflag_d;
      xpos_q  <= xpos_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
      sym_q   <= sym_d;
      adj_q   <= adj_d;
    end
  end

  assign bus.bit_out    = bit_q;
  assign bus.bit_valid  = bv_q;
  assign bus.sym_acc    = sym_q;
  assign bus.timing_adj = adj_q;

`ifdef LOCK_DET_EN
  logic [3:0]    lcnt_q, lcnt_d;
  logic          lock_q, lock_d;
  logic [AW-1:0] w_mag;
  logic          w_good;

  always_comb begin
    w_mag  = w_final[AW-1] ? AW'(-w_final) : AW'(w_final);
    w_good = (w_mag >= LOCK_TH);
    lcnt_d = lcnt_q;
    lock_d = lock_q;
    // Counter at 15 means 15 prior good symbols, so a good one now is the 16th.
    if (w_dump) begin
      if (w_good) begin
        lcnt_d = (lcnt_q == 4'd15) ? 4'd15 : lcnt_q + 4'd1;
        lock_d = (lcnt_q == 4'd15);
      end else begin
        lcnt_d = 4'd0;
        lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lcnt_q <= 4'd0;
      lock_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      lock_q <= lock_d;
    end
  end

  assign bus.lock = lock_q;
`else
  assign bus.lock = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpsk_bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_bit_sync
// Purpose  : Randomised and directed stimulus against a queue-based symbol model.
// Revision : 1.0
// ============================================================================
module tb_bpsk_bit_sync;
  localparam int    SPS     = 50;
  localparam longint LOCK_TH = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  bpsk_bit_sync_if #(.DW(32)) bus ();

  bpsk_bit_sync #(
    .DW(32), .SPS(SPS), .LOCK_TH(39'd20000)
  ) u_dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: collect the samples of the current symbol, evaluate it as a whole.
  longint   q[$];
  int       cur_len = SPS;
  bit       start_neg = 1'b0;
  int       good_run = 0;
  int       ndumps = 0;
  bit       e_bv = 0, e_bit = 0, e_lock = 0;
  bit [1:0] e_adj = 0;
  longint   e_acc = 0;

  task automatic model_reset();
    q.delete();
    cur_len = SPS; start_neg = 1'b0; good_run = 0;
    e_bv = 0; e_bit = 0; e_lock = 0; e_adj = 0; e_acc = 0;
  endtask

  task automatic model_accept(input longint s);
    longint sum;
    int     xp;
    bit     pn;
    bit     good;
    q.push_back(s);
    if (q.size() == cur_len) begin
      sum = 0; xp = -1; pn = start_neg;
      foreach (q[k]) begin
        sum += q[k];
        if (xp < 0 && ((q[k] < 0) != pn)) xp = k;
        pn = (q[k] < 0);
      end
      e_bv = 1; e_acc = sum; e_bit = (sum >= 0);
      if (xp <= 0) begin
        cur_len = SPS; e_adj = 2'b00;
      end else if (xp < SPS / 2) begin
        cur_len = SPS + 1; e_adj = 2'b01;
      end else begin
        cur_len = SPS - 1; e_adj = 2'b10;
      end
      good = ((sum < 0) ? -sum : sum) >= LOCK_TH;
      good_run = good ? good_run + 1 : 0;
`ifdef LOCK_DET_EN
      e_lock = (good_run >= 16);
`else
      e_lock = 1'b0;
`endif
      start_neg = pn;
      q.delete();
      ndumps++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [38:0] a_obs;
    logic [38:0] a_exp;
    a_obs = bus.sym_acc;
    a_exp = 39'(e_acc);
    chk("bit_valid", 64'(bus.bit_valid), 64'(e_bv));
    chk("timing_adj", 64'(bus.timing_adj), 64'(e_adj));
    chk("bit_out", 64'(bus.bit_out), 64'(e_bit));
    chk("sym_acc", {25'b0, a_obs}, {25'b0, a_exp});
    chk("lock", 64'(bus.lock), 64'(e_lock));
  endtask

  task automatic step(input longint s, input bit v);
    bus.din = 32'(s);
    bus.din_valid = v;
    @(posedge clk);
    e_bv = 0; e_adj = 2'b00;
    if (v) model_accept(s);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  // Square wave of +/-1000 with transitions at t = d, d+SPS, ...; starts positive.
  function automatic longint square(input int t, input int d);
    return ((((t + SPS - d) / SPS) % 2) == 0) ? 64'sd1000 : -64'sd1000;
  endfunction

  initial begin
    int     start;
    int     run_left;
    bit     neg;
    longint mag;

    bus.din = '0;
    bus.din_valid = 1'b0;
    do_reset();

    // Constant positive input, then one all-zero symbol, then recovery.
    start = ndumps;
    while (ndumps - start < 20) step(1000, 1'b1);
    start = ndumps;
    while (ndumps == start) step(0, 1'b1);
    start = ndumps;
    while (ndumps - start < 2) step(1000, 1'b1);
    repeat (10) step(1000, 1'b0);

    // Aligned, delayed and advanced square waves.
    do_reset();
    for (int t = 0; t < SPS * 8; t++) step(square(t, 0), 1'b1);
    do_reset();
    for (int t = 0; t < SPS * 12; t++) step(square(t, 5), 1'b1);
    do_reset();
    for (int t = 0; t < SPS * 12; t++) step(square(t, 45), 1'b1);

    // Random sign runs, magnitudes and valid gaps.
    do_reset();
    run_left = 0; neg = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (run_left == 0) begin
        neg = ($urandom_range(0, 1) == 1);
        run_left = $urandom_range(1, 80);
      end
      mag = longint'($urandom_range(0, 32'h3fff_ffff));
      if ($urandom_range(0, 3) != 0) begin
        run_left--;
        step(neg ? -mag : mag, 1'b1);
      end else begin
        step(mag, 1'b0);
      end
    end

    // Half-rate valid, then reset in the middle of a symbol.
    do_reset();
    for (int t = 0; t < 250; t++) step(1000, (t % 2) == 0);
    begin
      int guard = 0;
      while (q.size() != 20 && guard < 200) begin
        step(1000, (guard % 2) == 0);
        guard++;
      end
    end
    do_reset();
    for (int t = 0; t < 220; t++) step(-700, (t % 2) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
